fir_serial_mac_fir: RTL and testbench

- Parametrised, time-multiplexed N-tap FIR filter.
- Uses one multiplier-accumulator, iterated over all taps once per accepted input sample, instead of N parallel multipliers.
- Coefficients are loaded at run time through a write port, so one instance can serve as LPF, HPF or BPF.
- Has valid/ready input and output-valid handshakes. Sits between the ADC sample stage and downstream decimation/DAC logic.

---
 rtl/fir_serial_mac_fir.sv | 128 ++++++++++++
 tb/tb_fir_serial_mac_fir.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_serial_mac_fir.sv
// ============================================================================
// fir_serial_mac_fir : N-tap FIR built on one time-shared multiply-accumulator
// Revision: 1.0
// ============================================================================
`default_nettype none

module fir_serial_mac_fir #(
  parameter int N           = 51,
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int OUT_WIDTH   = 16,
  parameter int SHIFT       = 15,
  parameter int ROUND       = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic signed [DATA_WIDTH-1:0]  s_data,
  output logic                          m_valid,
  output logic signed [OUT_WIDTH-1:0]   m_data,
  output logic                          m_sat,
  input  logic                          coef_we,
  input  logic [$clog2(N)-1:0]          coef_addr,
  input  logic signed [COEFF_WIDTH-1:0] coef_data,
  output logic                          coef_err,
  output logic                          busy
);

  localparam int AW    = $clog2(N);
  localparam int PW    = DATA_WIDTH + COEFF_WIDTH;
  localparam int ACC_W = PW + $clog2(N);
  localparam int RB    = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic [AW:0]               N_X    = (AW+1)'(N);
  localparam logic [AW-1:0]             K_LAST = AW'(N - 1);
  localparam logic signed [ACC_W:0]     RND    = (ROUND != 0 && SHIFT > 0) ?
                                                 ((ACC_W+1)'(1) << RB) : '0;
  localparam logic signed [ACC_W:0]     OMAX_X = {{(ACC_W+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W:0]     OMIN_X = {{(ACC_W+2-OUT_WIDTH){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                         state;
  logic signed [DATA_WIDTH-1:0]   x [N];
  logic signed [COEFF_WIDTH-1:0]  h [N];
  logic signed [ACC_W-1:0]        acc;
  logic [AW-1:0]                  k;

  logic signed [PW-1:0]           prod;
  logic signed [ACC_W:0]          rounded;
  logic signed [ACC_W:0]          scaled;
  logic                           coef_ok;

  assign prod    = h[k] * x[k];
  assign rounded = {acc[ACC_W-1], acc} + RND;
  assign scaled  = rounded >>> SHIFT;
  // Writes land only between computations so a running sum never mixes coefficient sets.
  assign coef_ok = coef_we && (state == IDLE) && ({1'b0, coef_addr} < N_X);

  assign s_ready = (state == IDLE);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      acc      <= '0;
      k        <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_sat    <= 1'b0;
      coef_err <= 1'b0;
      for (int i = 0; i < N; i++) begin
        x[i] <= '0;
        h[i] <= '0;
      end
    end else begin
      m_valid  <= 1'b0;
      coef_err <= coef_we && !coef_ok;
      if (coef_ok) begin
        h[coef_addr] <= coef_data;
      end
      case (state)
        IDLE: begin
          if (s_valid) begin
            for (int i = N - 1; i > 0; i--) begin
              x[i] <= x[i-1];
            end
            x[0]  <= s_data;
            acc   <= '0;
            k     <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
          k   <= k + AW'(1);
          if (k == K_LAST) begin
            state <= OUT;
          end
        end
        OUT: begin
          m_valid <= 1'b1;
          if (scaled > OMAX_X) begin
            m_data <= OMAX_X[OUT_WIDTH-1:0];
            m_sat  <= 1'b1;
          end else if (scaled < OMIN_X) begin
            m_data <= OMIN_X[OUT_WIDTH-1:0];
            m_sat  <= 1'b1;
          end else begin
            m_data <= scaled[OUT_WIDTH-1:0];
            m_sat  <= 1'b0;
          end
          k     <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fir_serial_mac_fir.sv
// ============================================================================
// tb_fir_serial_mac_fir : checks two filter instances (ROUND=1 and ROUND=0)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fir_serial_mac_fir;

  localparam int N  = 51;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int OW = 16;
  localparam int AW = $clog2(N);

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 s_valid = 1'b0;
  logic signed [DW-1:0] s_data = '0;
  logic                 coef_we = 1'b0;
  logic [AW-1:0]        coef_addr = '0;
  logic signed [CW-1:0] coef_data = '0;

  logic                 s_ready, m_valid, m_sat, coef_err, busy;
  logic signed [OW-1:0] m_data;
  logic                 s_ready0, m_valid0, m_sat0, coef_err0, busy0;
  logic signed [OW-1:0] m_data0;

  fir_serial_mac_fir #(.N(N), .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .OUT_WIDTH(OW),
                       .SHIFT(15), .ROUND(1)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_data(m_data), .m_sat(m_sat), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err), .busy(busy));

  fir_serial_mac_fir #(.N(N), .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .OUT_WIDTH(OW),
                       .SHIFT(15), .ROUND(0)) dut0 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
    .m_valid(m_valid0), .m_data(m_data0), .m_sat(m_sat0), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err0), .busy(busy0));

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int d;
    int e1;
    bit s1;
    int e0;
    bit s0;
  } exp_t;

  typedef struct {
    int d;
    int e1;
    int e0;
  } vec_t;

  int hm [N];
  int xm [N];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void clip(input longint r, output int v, output bit s);
    if (r > 32767) begin
      v = 32767; s = 1'b1;
    end else if (r < -32768) begin
      v = -32768; s = 1'b1;
    end else begin
      v = int'(r); s = 1'b0;
    end
  endfunction

  // Reference: the output is the dot product of the coefficients with the
  // N most recent samples, scaled by 2^-15 with optional half-LSB rounding.
  function automatic exp_t model_accept(input int d);
    exp_t   e;
    longint a = 0;
    for (int i = N - 1; i > 0; i--) xm[i] = xm[i-1];
    xm[0] = d;
    for (int i = 0; i < N; i++) a += longint'(hm[i]) * longint'(xm[i]);
    e.d = d;
    clip((a + 64'sd16384) >>> 15, e.e1, e.s1);
    clip(a >>> 15, e.e0, e.s0);
    return e;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      hm[i] = 0;
      xm[i] = 0;
    end
  endfunction

  function automatic int rand16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic write_coef(input int addr, input int data, input bit exp_err, input string name);
    coef_we   = 1'b1;
    coef_addr = addr[AW-1:0];
    coef_data = data[CW-1:0];
    tick();
    coef_we = 1'b0;
    check({name, "_err"}, coef_err, exp_err);
    check({name, "_err0"}, coef_err0, exp_err);
    if (!exp_err) hm[addr] = int'(coef_data);
    tick();
    check({name, "_err_pulse"}, coef_err, 0);
  endtask

  task automatic start_sample(input int d, output int t0, output exp_t e);
    for (int i = 0; i < 200 && !s_ready; i++) tick();
    check("s_ready_wait", s_ready, 1);
    s_valid = 1'b1;
    s_data  = d[DW-1:0];
    tick();
    t0      = cycle;
    s_valid = 1'b0;
    e       = model_accept(d);
  endtask

  task automatic wait_out(input int t0, input exp_t e, input string name);
    bit got = 1'b0;
    int held;
    for (int i = 0; i < N + 20; i++) begin
      tick();
      if (m_valid) begin
        got = 1'b1;
        break;
      end
    end
    check({name, "_got"}, got, 1);
    if (got) begin
      check({name, "_latency"}, cycle - t0, N + 1);
      check({name, "_valid0"}, m_valid0, 1);
      check({name, "_data"}, int'(m_data), e.e1);
      check({name, "_sat"}, m_sat, e.s1);
      check({name, "_data0"}, int'(m_data0), e.e0);
      check({name, "_sat0"}, m_sat0, e.s0);
      held = int'(m_data);
      tick();
      check({name, "_pulse"}, m_valid, 0);
      check({name, "_hold"}, int'(m_data), held);
    end
  endtask

  task automatic send_check(input int d, input string name, output exp_t e);
    int t0;
    start_sample(d, t0, e);
    wait_out(t0, e, name);
  endtask

  initial begin
    vec_t  vecs [6];
    exp_t  e;
    exp_t  q [$];
    int    accq [$];
    int    t0, acc_n, out_n, last_acc, extra, addr;
    bit    was_ready;

    // Impulse response with h[0]=16384, h[1]=-8192 (ROUND=1 / ROUND=0 results).
    vecs[0] = '{d:  32767, e1:  16384, e0:  16383};
    vecs[1] = '{d:      0, e1:  -8192, e0:  -8192};
    vecs[2] = '{d:      0, e1:      0, e0:      0};
    vecs[3] = '{d: -32768, e1: -16384, e0: -16384};
    vecs[4] = '{d:    100, e1:   8242, e0:   8242};
    vecs[5] = '{d:      1, e1:    -24, e0:    -25};

    model_reset();
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", int'(m_data), 0);
    check("rst_m_sat", m_sat, 0);
    check("rst_coef_err", coef_err, 0);
    rst = 1'b1;
    tick();

    write_coef(0, 16384, 1'b0, "imp_h0");
    write_coef(1, -8192, 1'b0, "imp_h1");
    for (int i = 0; i < 6; i++) begin
      send_check(vecs[i].d, $sformatf("imp%0d", i), e);
      check($sformatf("imp%0d_tbl", i), int'(m_data), vecs[i].e1);
      check($sformatf("imp%0d_tbl0", i), int'(m_data0), vecs[i].e0);
    end

    // Coefficient writes during MAC and out of range are both rejected.
    start_sample(5000, t0, e);
    repeat (5) tick();
    check("mac_busy", busy, 1);
    check("mac_s_ready", s_ready, 0);
    write_coef(0, 12345, 1'b1, "wr_in_mac");
    wait_out(t0, e, "wr_in_mac_out");
    write_coef(51, 777, 1'b1, "wr_addr51");
    write_coef(63, 777, 1'b1, "wr_addr63");
    send_check(-3000, "after_bad_wr", e);

    // Rounding, then an aborted computation.
    do_reset();
    write_coef(0, 1, 1'b0, "rnd_h0");
    send_check(16384, "rnd", e);
    check("rnd_r1", int'(m_data), 1);
    check("rnd_r0", int'(m_data0), 0);
    start_sample(20000, t0, e);
    repeat (10) tick();
    rst = 1'b0;
    #1;
    check("abort_busy_async", busy, 0);
    tick();
    check("abort_busy", busy, 0);
    check("abort_s_ready", s_ready, 1);
    check("abort_m_valid", m_valid, 0);
    check("abort_m_data", int'(m_data), 0);
    check("abort_m_data0", int'(m_data0), 0);
    rst = 1'b1;
    model_reset();
    extra = 0;
    for (int i = 0; i < N + 5; i++) begin
      tick();
      if (m_valid) extra++;
    end
    check("abort_no_valid", extra, 0);
    send_check(1234, "after_abort", e);
    check("after_abort_zero", int'(m_data), 0);

    // Saturation in both directions.
    do_reset();
    for (int i = 0; i < N; i++) write_coef(i, 32767, 1'b0, "sat_h");
    for (int i = 0; i < N; i++) send_check(32767, "sat_pos", e);
    check("sat_pos_last", int'(m_data), 32767);
    check("sat_pos_flag", m_sat, 1);
    for (int i = 0; i < N; i++) send_check(-32768, "sat_neg", e);
    check("sat_neg_last", int'(m_data), -32768);
    check("sat_neg_flag", m_sat, 1);
    check("sat_neg_last0", int'(m_data0), -32768);

    // s_valid held high for five samples.
    do_reset();
    for (int i = 0; i < N; i++) write_coef(i, rand16() / 64, 1'b0, "bp_h");
    s_valid  = 1'b1;
    s_data   = rand16();
    acc_n    = 0;
    out_n    = 0;
    last_acc = 0;
    for (int c = 0; c < 5 * (N + 2) + 60 && out_n < 5; c++) begin
      was_ready = s_ready;
      tick();
      if (was_ready && s_valid) begin
        q.push_back(model_accept(int'(s_data)));
        if (acc_n > 0) check("bp_spacing", cycle - last_acc, N + 2);
        last_acc = cycle;
        accq.push_back(cycle);
        acc_n++;
        if (acc_n == 5) s_valid = 1'b0;
        else s_data = rand16();
      end
      if (m_valid) begin
        out_n++;
        if (q.size() == 0) begin
          check("bp_unexpected", 1, 0);
        end else begin
          e = q.pop_front();
          check("bp_latency", cycle - accq.pop_front(), N + 1);
          check("bp_data", int'(m_data), e.e1);
          check("bp_data0", int'(m_data0), e.e0);
        end
      end
    end
    extra = 0;
    for (int i = 0; i < N + 5; i++) begin
      tick();
      if (m_valid) extra++;
    end
    check("bp_count", out_n + extra, 5);

    // Randomised coefficients (some writes out of range) and samples.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) begin
        addr = int'($urandom_range(0, 63));
        write_coef(addr, rand16(), addr >= N, "rnd_wr");
      end
      for (int i = 0; i < 10; i++) send_check(rand16(), "rand", e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
